// File: rtl/hdmi_out_pkg.sv
// Shared types and default widths for the HDMI output line fetch path.
package hdmi_out_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_LEN_W       = 16;
  localparam int unsigned DEF_BURST_BYTES = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_LINE_WAIT = 3'd2,
    ST_BURST     = 3'd3,
    ST_LINE_END  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// One-register rising-edge detector for sync inputs; pulse is combinational.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_c
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise_c = level & ~level_q;

endmodule

// File: rtl/line_fetch_seq.sv
// Per-line DDR burst request sequencer: walks a frame line by line on hsync,
// issuing BURST_BYTES-sized read requests gated by pixel FIFO space.
module line_fetch_seq #(
  parameter int unsigned ADDR_W      = hdmi_out_pkg::DEF_ADDR_W,
  parameter int unsigned LEN_W       = hdmi_out_pkg::DEF_LEN_W,
  parameter int unsigned BURST_BYTES = hdmi_out_pkg::DEF_BURST_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic [LEN_W-1:0]  pixels_per_line,
  input  logic [2:0]        bytes_per_pixel,
  input  logic [LEN_W-1:0]  lines_per_frame,
  input  logic              fifo_space_ok,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              line_done,
  output logic              frame_done,
  output logic              overrun
);

  import hdmi_out_pkg::*;

  // Wide enough for pixels*bytes plus the round-up term without truncation.
  localparam int unsigned CNT_W    = LEN_W + 4;
  localparam int unsigned BB_SHIFT = $clog2(BURST_BYTES);

  fetch_state_t state, state_nx;

  logic              hs_rise, vs_rise;
  logic              accept, last_burst, last_line, vs_go, reload;
  logic [CNT_W-1:0]  burst_total;
  logic [LEN_W-1:0]  lines_eff;

  logic              vs_pend,    vs_pend_nx;
  logic [CNT_W-1:0]  burst_idx,  burst_idx_nx;
  logic [ADDR_W-1:0] burst_addr, burst_addr_nx;
  logic [ADDR_W-1:0] line_addr,  line_addr_nx;
  logic [LEN_W-1:0]  line_idx,   line_idx_nx;
  logic [ADDR_W-1:0] lat_stride, lat_stride_nx;
  logic [LEN_W-1:0]  lat_lines,  lat_lines_nx;
  logic [CNT_W-1:0]  lat_bursts, lat_bursts_nx;
  logic              rd_req_nx, line_done_nx, frame_done_nx, overrun_nx;
  logic [ADDR_W-1:0] rd_addr_nx;

  sync_edge_det u_hs (.clk(clk), .reset(reset), .level(hsync), .rise_c(hs_rise));
  sync_edge_det u_vs (.clk(clk), .reset(reset), .level(vsync), .rise_c(vs_rise));

  assign burst_total = (CNT_W'(pixels_per_line) * CNT_W'(bytes_per_pixel)
                        + CNT_W'(BURST_BYTES - 1)) >> BB_SHIFT;
  assign lines_eff   = (lines_per_frame == '0) ? LEN_W'(1) : lines_per_frame;
  assign accept      = rd_req & rd_ack;
  assign last_burst  = (burst_idx == lat_bursts - CNT_W'(1));
  assign last_line   = (line_idx == lat_lines - LEN_W'(1));
  assign vs_go       = vs_rise | vs_pend;
  // Inside a burst the frame restart waits for any open handshake to close.
  assign reload      = (state == ST_BURST) ? (start & vs_go & (~rd_req | rd_ack)) : vs_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!start) begin
      if (!(rd_req && !rd_ack)) state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_nx = ST_ARM;
        ST_ARM:       if (vs_rise) state_nx = ST_LINE_WAIT;
        ST_LINE_WAIT: if (!vs_rise && hs_rise)
                        state_nx = (lat_bursts != '0) ? ST_BURST : ST_LINE_END;
        ST_BURST:     if (vs_go && (!rd_req || rd_ack)) state_nx = ST_LINE_WAIT;
                      else if (accept && last_burst)    state_nx = ST_LINE_END;
        ST_LINE_END:  state_nx = (vs_rise || !last_line) ? ST_LINE_WAIT : ST_ARM;
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_req_nx     = rd_req;
    rd_addr_nx    = rd_addr;
    line_done_nx  = 1'b0;
    frame_done_nx = 1'b0;
    overrun_nx    = overrun;
    vs_pend_nx    = vs_pend;
    burst_idx_nx  = burst_idx;
    burst_addr_nx = burst_addr;
    line_addr_nx  = line_addr;
    line_idx_nx   = line_idx;
    lat_stride_nx = lat_stride;
    lat_lines_nx  = lat_lines;
    lat_bursts_nx = lat_bursts;

    if (state == ST_IDLE && state_nx == ST_ARM) overrun_nx = 1'b0;
    if (hs_rise && (state == ST_BURST || state == ST_LINE_END)) overrun_nx = 1'b1;

    if (accept) begin
      rd_req_nx     = 1'b0;
      burst_idx_nx  = burst_idx + CNT_W'(1);
      burst_addr_nx = burst_addr + ADDR_W'(BURST_BYTES);
    end else if (state == ST_BURST && state_nx == ST_BURST && !rd_req && fifo_space_ok) begin
      rd_req_nx  = 1'b1;
      rd_addr_nx = burst_addr;
    end

    if (state == ST_BURST && vs_rise && rd_req && !rd_ack) vs_pend_nx = 1'b1;
    if (state_nx != ST_BURST) vs_pend_nx = 1'b0;

    if (state == ST_LINE_WAIT && state_nx == ST_BURST) begin
      burst_idx_nx  = '0;
      burst_addr_nx = line_addr;
    end

    // LINE_END never self-loops, so this marks entry into it.
    if (state_nx == ST_LINE_END) begin
      line_done_nx  = 1'b1;
      frame_done_nx = last_line;
    end

    if (state == ST_LINE_END) begin
      line_addr_nx = line_addr + lat_stride;
      line_idx_nx  = line_idx + LEN_W'(1);
    end

    if (reload) begin
      lat_stride_nx = line_stride;
      lat_lines_nx  = lines_eff;
      lat_bursts_nx = burst_total;
      line_idx_nx   = '0;
      line_addr_nx  = frame_base;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      vs_pend    <= 1'b0;
      burst_idx  <= '0;
      burst_addr <= '0;
      line_addr  <= '0;
      line_idx   <= '0;
      lat_stride <= '0;
      lat_lines  <= '0;
      lat_bursts <= '0;
    end else begin
      rd_req     <= rd_req_nx;
      rd_addr    <= rd_addr_nx;
      line_done  <= line_done_nx;
      frame_done <= frame_done_nx;
      overrun    <= overrun_nx;
      vs_pend    <= vs_pend_nx;
      burst_idx  <= burst_idx_nx;
      burst_addr <= burst_addr_nx;
      line_addr  <= line_addr_nx;
      line_idx   <= line_idx_nx;
      lat_stride <= lat_stride_nx;
      lat_lines  <= lat_lines_nx;
      lat_bursts <= lat_bursts_nx;
    end
  end

endmodule

// File: tb/tb_line_fetch_seq.sv
// Directed bench for line_fetch_seq: DDR responder with an address scoreboard.
module tb_line_fetch_seq;

  import hdmi_out_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 16;
  localparam logic [31:0] BB     = 32'd64;

  logic              clk, reset, start, hsync, vsync, fifo_space_ok, rd_ack;
  logic [ADDR_W-1:0] frame_base, line_stride, rd_addr;
  logic [LEN_W-1:0]  pixels_per_line, lines_per_frame;
  logic [2:0]        bytes_per_pixel;
  logic              rd_req, line_done, frame_done, overrun;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          ack_delay = 0, wait_cnt = 0, acc_in_line = 0, exp_bursts = 0;
  int          n_acc = 0, n_line_done = 0, n_frame_done = 0, frame_at = 0, stall_left = 0;
  bit          req_seen = 0, gap_due = 0, stall_arm = 0;
  logic [31:0] req_addr;

  line_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start), .hsync(hsync), .vsync(vsync),
    .frame_base(frame_base), .line_stride(line_stride),
    .pixels_per_line(pixels_per_line), .bytes_per_pixel(bytes_per_pixel),
    .lines_per_frame(lines_per_frame), .fifo_space_ok(fifo_space_ok),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .line_done(line_done), .frame_done(frame_done), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: observe outputs at negedge, then act as the DDR read port.
  task automatic tick();
    @(negedge clk);
    if (line_done) begin
      n_line_done++;
      chk("bursts_per_line", 32'(acc_in_line), 32'(exp_bursts));
    end
    if (frame_done) begin
      n_frame_done++;
      frame_at = n_line_done;
      chk("frame_with_line", 32'(line_done), 32'd1);
    end
    if (gap_due) begin
      chk("req_gap_after_ack", 32'(rd_req), 32'd0);
      gap_due = 0;
    end
    rd_ack = 1'b0;
    if (req_seen) begin
      chk("req_hold", 32'(rd_req), 32'd1);
      chk("addr_hold", rd_addr, req_addr);
    end
    if (rd_req) begin
      if (!req_seen) begin
        req_seen = 1;
        req_addr = rd_addr;
        wait_cnt = 0;
        if (stall_arm) begin
          stall_arm     = 0;
          stall_left    = 6;
          fifo_space_ok = 1'b0;
        end
      end
      if (wait_cnt >= ack_delay) begin
        rd_ack   = 1'b1;
        req_seen = 0;
        gap_due  = 1;
        acc_in_line++;
        n_acc++;
        if (exp_q.size() == 0) chk("req_expected_qsize", 32'(exp_q.size()), 32'd1);
        else                   chk("rd_addr", rd_addr, exp_q.pop_front());
      end else begin
        wait_cnt++;
      end
    end else begin
      req_seen = 0;
    end
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) fifo_space_ok = 1'b1;
    end
  endtask

  task automatic set_cfg(input logic [31:0] base, input logic [31:0] stride,
                         input int px, input int bpp, input int lines);
    frame_base      = base;
    line_stride     = stride;
    pixels_per_line = LEN_W'(px);
    bytes_per_pixel = 3'(bpp);
    lines_per_frame = LEN_W'(lines);
  endtask

  task automatic pulse_hsync();
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
  endtask

  task automatic wait_line(input int ld0);
    int t = 0;
    while (n_line_done == ld0 && t < 3000) begin
      tick();
      t++;
    end
    chk("line_done_seen", 32'(n_line_done), 32'(ld0 + 1));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Fetch one line of nb bursts from addr; optionally re-pulse hsync after ovr_at acks.
  task automatic do_line(input int nb, input logic [31:0] addr, input int ovr_at);
    int ld0;
    int t;
    repeat (2) tick();
    for (int k = 0; k < nb; k++) exp_q.push_back(addr + 32'(k) * BB);
    exp_bursts  = nb;
    acc_in_line = 0;
    ld0         = n_line_done;
    pulse_hsync();
    if (ovr_at >= 0) begin
      t = 0;
      while (acc_in_line < ovr_at && t < 500) begin
        tick();
        t++;
      end
      pulse_hsync();
    end
    wait_line(ld0);
  endtask

  initial begin
    int acc0;
    int ld0;
    int t;
    reset = 1'b1; start = 1'b0; hsync = 1'b0; vsync = 1'b0;
    fifo_space_ok = 1'b1; rd_ack = 1'b0;
    set_cfg(32'h0, 32'h0, 0, 1, 1);
    repeat (3) @(negedge clk);
    chk("reset_rd_req", 32'(rd_req), 32'd0);
    chk("reset_rd_addr", rd_addr, 32'd0);
    chk("reset_line_done", 32'(line_done), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(ST_IDLE));
    reset = 1'b0; start = 1'b1;
    repeat (2) tick();

    // 640 px x 4 B, 3 lines: 40 bursts per line, frame_done on line 3
    set_cfg(32'h1000_0000, 32'h1400, 640, 4, 3);
    pulse_vsync();
    for (int l = 0; l < 3; l++) do_line(40, 32'h1000_0000 + 32'(l) * 32'h1400, -1);
    chk("frame_done_count_a", 32'(n_frame_done), 32'd1);
    chk("frame_on_third_line", 32'(frame_at), 32'd3);

    // Frame complete: hsync ignored until the next vsync
    acc0 = n_acc; ld0 = n_line_done;
    repeat (2) tick();
    pulse_hsync();
    repeat (20) tick();
    chk("arm_ignores_hsync_req", 32'(n_acc), 32'(acc0));
    chk("arm_ignores_hsync_line", 32'(n_line_done), 32'(ld0));
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // 10 px x 3 B = 30 B rounds up to a single burst
    set_cfg(32'h2000_0000, 32'h100, 10, 3, 2);
    pulse_vsync();
    do_line(1, 32'h2000_0000, -1);
    do_line(1, 32'h2000_0100, -1);
    chk("frame_done_count_b", 32'(n_frame_done), 32'd2);
    chk("frame_at_b", 32'(frame_at), 32'd5);

    // No request without FIFO space; held request stays put through a stall and slow ack
    set_cfg(32'h3000_0000, 32'h100, 32, 4, 1);
    pulse_vsync();
    repeat (2) tick();
    fifo_space_ok = 1'b0;
    acc0 = n_acc; ld0 = n_line_done;
    exp_q.push_back(32'h3000_0000);
    exp_q.push_back(32'h3000_0040);
    exp_bursts = 2; acc_in_line = 0;
    pulse_hsync();
    repeat (8) tick();
    chk("no_req_without_space", 32'(rd_req), 32'd0);
    chk("no_accept_without_space", 32'(n_acc), 32'(acc0));
    ack_delay = 7; stall_arm = 1; fifo_space_ok = 1'b1;
    wait_line(ld0);
    ack_delay = 0;
    chk("frame_done_count_c", 32'(n_frame_done), 32'd3);

    // hsync during burst 3 sets overrun but leaves the sequence intact
    set_cfg(32'h4000_0000, 32'h2000, 640, 4, 3);
    pulse_vsync();
    do_line(40, 32'h4000_0000, 2);
    chk("overrun_set", 32'(overrun), 32'd1);

    // vsync mid-line: open handshake completes, next line starts at new frame_base
    repeat (2) tick();
    for (int k = 0; k < 40; k++) exp_q.push_back(32'h4000_2000 + 32'(k) * BB);
    exp_bursts = 40; acc_in_line = 0; ld0 = n_line_done;
    pulse_hsync();
    t = 0;
    while (acc_in_line < 5 && t < 500) begin
      tick();
      t++;
    end
    set_cfg(32'h5000_0000, 32'h100, 64, 4, 1);
    pulse_vsync();
    repeat (10) tick();
    chk("vsync_handshake_count", 32'(acc_in_line >= 5 && acc_in_line <= 6), 32'd1);
    chk("vsync_no_line_done", 32'(n_line_done), 32'(ld0));
    exp_q.delete();
    do_line(4, 32'h5000_0000, -1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    chk("frame_done_count_d", 32'(n_frame_done), 32'd4);

    // Address wrap past 2^32; lines_per_frame=0 acts as one line
    set_cfg(32'hFFFF_FFC0, 32'h100, 32, 4, 0);
    pulse_vsync();
    do_line(2, 32'hFFFF_FFC0, -1);
    chk("frame_done_count_e", 32'(n_frame_done), 32'd5);

    // Reset while a request is outstanding drops it at once
    set_cfg(32'h6000_0000, 32'h100, 640, 4, 2);
    ack_delay = 50;
    pulse_vsync();
    repeat (2) tick();
    pulse_hsync();
    t = 0;
    while (!req_seen && t < 200) begin
      tick();
      t++;
    end
    chk("req_before_reset", 32'(rd_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_drops_req", 32'(rd_req), 32'd0);
    chk("reset_state_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("reset_clears_overrun", 32'(overrun), 32'd0);
    req_seen = 0; gap_due = 0; exp_q.delete();
    repeat (3) tick();
    reset = 1'b0; ack_delay = 0;

    // Zero-length line: line_done with no request
    set_cfg(32'h6000_0000, 32'h100, 0, 4, 2);
    repeat (2) tick();
    pulse_vsync();
    acc0 = n_acc;
    do_line(0, 32'h6000_0000, -1);
    chk("zero_len_no_req", 32'(n_acc), 32'(acc0));
    chk("frame_done_count_f", 32'(n_frame_done), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_fetch_seq.md
LINE_FETCH_SEQ -- requirements
Module: line_fetch_seq

Interface
REQ-001 Parameter ADDR_W, 32, width of DDR byte addresses and stride.
REQ-002 Parameter LEN_W, 16, width of pixel and line counts.
REQ-003 Parameter BURST_BYTES, 64, bytes per read burst; power of two, 4..1024.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 start  in  1  level enable; 0 = stop after any outstanding burst.
REQ-007 hsync  in  1  line sync; rising edge starts a line fetch.
REQ-008 vsync  in  1  frame sync; rising edge restarts the frame.
REQ-009 frame_base  in  ADDR_W  byte address of line 0.
REQ-010 line_stride  in  ADDR_W  byte distance between line starts.
REQ-011 pixels_per_line  in  LEN_W  active pixels per line.
REQ-012 bytes_per_pixel  in  3  value 1..4.
REQ-013 lines_per_frame  in  LEN_W  active lines per frame.
REQ-014 fifo_space_ok  in  1  pixel FIFO can accept one full burst.
REQ-015 rd_req  out  1  burst request to DDR read port.
REQ-016 rd_addr  out  ADDR_W  burst start address, valid while rd_req=1.
REQ-017 rd_ack  in  1  DDR port accepted the request this cycle.
REQ-018 line_done  out  1  one-cycle pulse after the last burst of a line is acked.
REQ-019 frame_done  out  1  one-cycle pulse coincident with line_done of the last line.
REQ-020 overrun  out  1  sticky; hsync rose while a line fetch was in progress.

Function
REQ-021 hsync/vsync rising edges are detected with one register stage; an action occurs the cycle after the edge is sampled.
REQ-022 States: IDLE, ARM, LINE_WAIT, BURST, LINE_END.
REQ-023 IDLE -> ARM when start=1; ARM -> LINE_WAIT on a vsync edge.
REQ-024 Every vsync edge latches frame_base, line_stride, lines_per_frame and burst count, and sets line index=0 and line_addr=frame_base.
REQ-025 Burst count = ceil(pixels_per_line*bytes_per_pixel / BURST_BYTES), computed at full width without truncation.
REQ-026 LINE_WAIT -> BURST on an hsync edge when burst count>0; with burst count=0, go to LINE_END directly and issue no request.
REQ-027 In BURST, rd_req=1 only when fifo_space_ok=1; rd_addr = line_addr + k*BURST_BYTES, k = burst index from 0.
REQ-028 Once rd_req is asserted, rd_req and rd_addr hold stable until rd_ack=1, regardless of fifo_space_ok.
REQ-029 rd_ack without rd_req is ignored; after rd_ack, rd_req drops for at least one cycle.
REQ-030 After the last burst is acked -> LINE_END: line_done=1 for one cycle, line_addr += line_stride, line index +1, then -> LINE_WAIT.
REQ-031 When the completed line index = lines_per_frame-1, frame_done pulses with line_done, then -> ARM; further hsync edges are ignored until vsync.
REQ-032 An hsync edge in BURST or LINE_END sets overrun and is otherwise ignored.
REQ-033 A vsync edge in BURST completes the current request handshake, then performs the REQ-024 reload without a line_done pulse.
REQ-034 start=0 with an outstanding rd_req waits for rd_ack, then -> IDLE; otherwise -> IDLE next cycle.
REQ-035 All address arithmetic wraps modulo 2^ADDR_W.
REQ-036 lines_per_frame=0 is treated as 1.

Reset
REQ-037 Reset forces IDLE; rd_req, line_done, frame_done and overrun are 0; rd_addr, counters and latched registers are 0.
REQ-038 Reset asserted mid-handshake drops rd_req immediately, with no completion.
REQ-039 overrun clears only on reset or on the IDLE -> ARM transition.

Structure
REQ-040 Shared package hdmi_out_pkg holds the state enumeration and the default BURST_BYTES, ADDR_W and LEN_W constants.
REQ-041 Sub-module sync_edge_det (register plus rising-edge pulse) is instantiated for hsync and vsync.

Verification
REQ-042 Stimulus: base=0x1000_0000, stride=0x1400, 640 px, 4 B/px, 3 lines, ack 1 cycle after each req. Response: 40 bursts per line at 0x1000_0000..0x1000_09C0 step 0x40, line 1 at 0x1000_1400, frame_done on the 3rd line_done.
REQ-043 Stimulus: 10 px, 3 B/px. Response: exactly 1 burst per line (30 B rounds up).
REQ-044 Stimulus: fifo_space_ok=0 for 5 cycles with rd_req high, ack delayed by 7 cycles. Response: rd_req and rd_addr constant throughout.
REQ-045 Stimulus: hsync edge during burst 3 of 40. Response: overrun=1, burst sequence unchanged; vsync mid-line → the current handshake completes, next address = new frame_base.
REQ-046 Stimulus: base=0xFFFF_FFC0 with BURST_BYTES=64. Response: second burst address is 0x0000_0000.
REQ-047 Stimulus: reset asserted with rd_req=1. Response: rd_req=0 asynchronously, state IDLE; pixels_per_line=0 → line_done with no rd_req.
